// File: rtl/ex3_pkg.sv
// ----------------------------------------------------------------------------
// ex3_pkg
// Shared types and constants for the bit-serial Excess-3 to BCD decoder.
//   state_e      : decoder FSM state (bit position + incoming borrow)
//   EX3_BIAS     : Excess-3 bias; bit i is the subtrahend bit at position i
//   BCD_MAX      : largest legal decoded digit
//   state_pos    : bit position (0..3) represented by a state
//   state_borrow : borrow-in carried by a state
// ----------------------------------------------------------------------------
package ex3_pkg;

    localparam int unsigned DIG_W = 4;
    localparam int unsigned POS_W = 2;

    localparam logic [DIG_W-1:0] EX3_BIAS = 4'b0011;
    localparam logic [DIG_W-1:0] BCD_MAX  = 4'd9;

    // NB = no borrow into this bit, B = borrow into this bit
    typedef enum logic [2:0] {
        B0    = 3'd0,
        B1_NB = 3'd1,
        B1_B  = 3'd2,
        B2_NB = 3'd3,
        B2_B  = 3'd4,
        B3_NB = 3'd5,
        B3_B  = 3'd6
    } state_e;

    // Bit position handled by a state; unused encodings fold onto bit 0
    function automatic logic [POS_W-1:0] state_pos(input state_e s);
        logic [POS_W-1:0] pos;
        pos = POS_W'(0);
        case (s)
            B1_NB, B1_B: pos = POS_W'(1);
            B2_NB, B2_B: pos = POS_W'(2);
            B3_NB, B3_B: pos = POS_W'(3);
            default:     pos = POS_W'(0);
        endcase
        return pos;
    endfunction

    // Borrow into the bit handled by a state
    function automatic logic state_borrow(input state_e s);
        logic b;
        b = 1'b0;
        case (s)
            B1_B, B2_B, B3_B: b = 1'b1;
            default:          b = 1'b0;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/ser_fsub_cell.sv
// ----------------------------------------------------------------------------
// ser_fsub_cell
// Combinational 1-bit full subtractor: d = x - k - b_in.
//   x     : minuend bit
//   k     : subtrahend bit
//   b_in  : borrow in
//   d     : difference bit
//   b_out : borrow out
// ----------------------------------------------------------------------------
module ser_fsub_cell (
    input  logic x,
    input  logic k,
    input  logic b_in,
    output logic d,
    output logic b_out
);

    assign d     = x ^ k ^ b_in;
    assign b_out = (~x & k) | (~x & b_in) | (k & b_in);

endmodule

// File: rtl/ex3_to_bcd_ser.sv
// ----------------------------------------------------------------------------
// ex3_to_bcd_ser
// Bit-serial Excess-3 to BCD decoder. Accepts one Excess-3 bit per qualified
// cycle, LSB first, and subtracts 3 serially. The BCD bit stream is produced
// combinationally; each completed digit is also presented as a registered
// 4-bit value with a one-cycle strobe and an invalid-code flag.
//   clk_i     : clock, rising edge
//   rst_i     : synchronous active-high reset
//   ser_i     : Excess-3 data bit, LSB first
//   vld_i     : qualifies ser_i
//   sof_i     : with vld_i, forces the current bit to be bit 0 of a digit
//   ser_o     : BCD bit for the accepted ser_i (0 when vld_i is low)
//   ser_vld_o : qualifies ser_o (mirrors vld_i)
//   bcd_o4    : last decoded digit (Excess-3 minus 3, mod 16)
//   dig_vld_o : one-cycle strobe, bcd_o4/err_o valid
//   err_o     : digit was not a legal Excess-3 code
// ----------------------------------------------------------------------------
module ex3_to_bcd_ser
    import ex3_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             ser_i,
    input  logic             vld_i,
    input  logic             sof_i,
    output logic             ser_o,
    output logic             ser_vld_o,
    output logic [DIG_W-1:0] bcd_o4,
    output logic             dig_vld_o,
    output logic             err_o
);

    state_e             r_state;
    state_e             w_state_eff;
    state_e             w_state_nxt;
    logic [POS_W-1:0]   w_pos;
    logic               w_k;
    logic               w_b_in;
    logic               w_d;
    logic               w_b_out;
    logic [DIG_W-1:0]   r_asm;
    logic [DIG_W-1:0]   w_asm_nxt;
    logic               w_dig_done;
    logic               w_dig_err;
    logic [DIG_W-1:0]   r_bcd;
    logic               r_dig_vld;
    logic               r_err;

    // Effective state: a start-of-digit bit restarts framing at bit 0
    always_comb begin
        w_state_eff = r_state;
        if (vld_i && sof_i) begin
            w_state_eff = B0;
        end
        w_pos  = state_pos(w_state_eff);
        w_k    = EX3_BIAS[w_pos];
        w_b_in = state_borrow(w_state_eff);
    end

    ser_fsub_cell u_fsub (
        .x     (ser_i),
        .k     (w_k),
        .b_in  (w_b_in),
        .d     (w_d),
        .b_out (w_b_out)
    );

    // FSM state register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= B0;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, assembly update and serial outputs
    always_comb begin
        w_state_nxt = r_state;
        w_asm_nxt   = r_asm;
        w_dig_done  = 1'b0;
        w_dig_err   = 1'b0;
        ser_o       = 1'b0;
        ser_vld_o   = vld_i;

        if (vld_i) begin
            ser_o            = w_d;
            // Each position is rewritten before bit 3, so stale bits from an
            // abandoned digit never reach the output.
            w_asm_nxt[w_pos] = w_d;
            case (w_pos)
                POS_W'(0): w_state_nxt = w_b_out ? B1_B : B1_NB;
                POS_W'(1): w_state_nxt = w_b_out ? B2_B : B2_NB;
                POS_W'(2): w_state_nxt = w_b_out ? B3_B : B3_NB;
                default: begin
                    w_state_nxt = B0;
                    w_dig_done  = 1'b1;
                    // Final borrow means input < 3; otherwise check the BCD range
                    w_dig_err   = w_b_out | (w_asm_nxt > BCD_MAX);
                end
            endcase
        end
    end

    // Assembly and digit output registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_asm     <= '0;
            r_bcd     <= '0;
            r_dig_vld <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_asm     <= w_asm_nxt;
            r_dig_vld <= w_dig_done;
            r_err     <= w_dig_done & w_dig_err;
            if (w_dig_done) begin
                r_bcd <= w_asm_nxt;
            end
        end
    end

    assign bcd_o4    = r_bcd;
    assign dig_vld_o = r_dig_vld;
    assign err_o     = r_err;

endmodule

// File: tb/tb_ex3_to_bcd_ser.sv
// ----------------------------------------------------------------------------
// tb_ex3_to_bcd_ser
// Self-checking bench for ex3_to_bcd_ser. Expected serial bits and digits are
// derived arithmetically from each Excess-3 code and queued as stimulus is
// driven; a negedge monitor pops and compares them as the DUT produces output.
// ----------------------------------------------------------------------------
module tb_ex3_to_bcd_ser;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       ser_i;
    logic       vld_i;
    logic       sof_i;
    logic       ser_o;
    logic       ser_vld_o;
    logic [3:0] bcd_o4;
    logic       dig_vld_o;
    logic       err_o;

    typedef struct packed {
        logic [3:0] bcd;
        logic       err;
    } dig_t;

    dig_t exp_dig_q[$];
    logic exp_ser_q[$];
    int   strobe_cyc_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    bit   mon_en = 1'b0;
    logic mon_e;
    dig_t mon_d;

    ex3_to_bcd_ser dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .ser_i     (ser_i),
        .vld_i     (vld_i),
        .sof_i     (sof_i),
        .ser_o     (ser_o),
        .ser_vld_o (ser_vld_o),
        .bcd_o4    (bcd_o4),
        .dig_vld_o (dig_vld_o),
        .err_o     (err_o)
    );

    always #5 clk_i = ~clk_i;

    // Scoreboard monitor, sampled mid-cycle
    always @(negedge clk_i) begin
        cyc++;
        if (mon_en) begin
            checks++;
            if (ser_vld_o !== vld_i) begin
                errors++;
                $display("FAIL ser_vld: got %b want %b at cyc %0d", ser_vld_o, vld_i, cyc);
            end
            if (vld_i === 1'b1) begin
                checks++;
                if (exp_ser_q.size() == 0) begin
                    errors++;
                    $display("FAIL ser_bit: got %b with no expected bit at cyc %0d", ser_o, cyc);
                end else begin
                    mon_e = exp_ser_q.pop_front();
                    if (ser_o !== mon_e) begin
                        errors++;
                        $display("FAIL ser_bit: got %b want %b at cyc %0d", ser_o, mon_e, cyc);
                    end
                end
            end else begin
                checks++;
                if (ser_o !== 1'b0) begin
                    errors++;
                    $display("FAIL ser_idle: got %b want 0 at cyc %0d", ser_o, cyc);
                end
            end
            if (dig_vld_o === 1'b1) begin
                strobe_cyc_q.push_back(cyc);
                checks++;
                if (exp_dig_q.size() == 0) begin
                    errors++;
                    $display("FAIL strobe_unexpected: bcd %b err %b, none expected at cyc %0d",
                             bcd_o4, err_o, cyc);
                end else begin
                    mon_d = exp_dig_q.pop_front();
                    if (bcd_o4 !== mon_d.bcd || err_o !== mon_d.err) begin
                        errors++;
                        $display("FAIL digit: got bcd %b err %b want bcd %b err %b at cyc %0d",
                                 bcd_o4, err_o, mon_d.bcd, mon_d.err, cyc);
                    end
                end
            end else begin
                checks++;
                if (dig_vld_o !== 1'b0 || err_o !== 1'b0) begin
                    errors++;
                    $display("FAIL idle_flags: dig_vld %b err %b want 0 0 at cyc %0d",
                             dig_vld_o, err_o, cyc);
                end
            end
        end
    end

    task automatic drive(input logic v, input logic x, input logic s, input logic r);
        @(posedge clk_i);
        #1;
        vld_i = v;
        ser_i = x;
        sof_i = s;
        rst_i = r;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Queue expected serial bit i of (code - 3); bit i depends only on bits 0..i
    task automatic push_ser(input logic [3:0] code, input int i);
        logic [3:0] diff;
        diff = 4'(code - 4'd3);
        exp_ser_q.push_back(diff[i]);
    endtask

    task automatic send_digit(input logic [3:0] code, input bit use_sof, input int gap);
        logic [3:0] diff;
        logic       bad;
        diff = 4'(code - 4'd3);
        bad  = (code < 4'd3) || (code > 4'd12);
        for (int i = 0; i < 4; i++) begin
            push_ser(code, i);
            if (i == 3) exp_dig_q.push_back({diff, bad});
            drive(1'b1, code[i], use_sof && (i == 0), 1'b0);
            if (i < 3) idle(gap);
        end
    endtask

    // Bounded wait for all queued expectations to be consumed
    task automatic drain(input string name);
        for (int i = 0; i < 12; i++) begin
            if (exp_dig_q.size() == 0 && exp_ser_q.size() == 0) break;
            idle(1);
        end
        idle(2);
        checks++;
        if (exp_dig_q.size() != 0 || exp_ser_q.size() != 0) begin
            errors++;
            $display("FAIL drain_%s: pending digits %0d bits %0d want 0 0",
                     name, exp_dig_q.size(), exp_ser_q.size());
            exp_dig_q.delete();
            exp_ser_q.delete();
        end
    endtask

    task automatic test_reset();
        vld_i = 1'b0; ser_i = 1'b0; sof_i = 1'b0; rst_i = 1'b1;
        do_reset();
        mon_en = 1'b1;
        @(negedge clk_i);
        checks++;
        if (bcd_o4 !== 4'b0000 || dig_vld_o !== 1'b0 || err_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: bcd %b dig_vld %b err %b want 0000 0 0",
                     bcd_o4, dig_vld_o, err_o);
        end
    endtask

    task automatic test_legal_min();
        do_reset();
        strobe_cyc_q.delete();
        send_digit(4'd3, 1'b0, 0);
        drain("legal_min");
        checks++;
        if (strobe_cyc_q.size() != 1) begin
            errors++;
            $display("FAIL legal_min_strobes: got %0d want 1", strobe_cyc_q.size());
        end
    endtask

    task automatic test_all_legal();
        strobe_cyc_q.delete();
        for (int c = 3; c <= 12; c++) send_digit(4'(c), 1'b1, 0);
        drain("all_legal");
        checks++;
        if (strobe_cyc_q.size() != 10) begin
            errors++;
            $display("FAIL all_legal_strobes: got %0d want 10", strobe_cyc_q.size());
        end else begin
            for (int i = 1; i < 10; i++) begin
                checks++;
                if (strobe_cyc_q[i] - strobe_cyc_q[i-1] != 4) begin
                    errors++;
                    $display("FAIL all_legal_spacing: strobe %0d gap %0d want 4",
                             i, strobe_cyc_q[i] - strobe_cyc_q[i-1]);
                end
            end
        end
    endtask

    task automatic test_illegal();
        send_digit(4'b0010, 1'b1, 0);
        send_digit(4'b1101, 1'b1, 0);
        send_digit(4'b0000, 1'b1, 0);
        drain("illegal");
        idle(3);
        checks++;
        if (bcd_o4 !== 4'b1101 || err_o !== 1'b0) begin
            errors++;
            $display("FAIL illegal_hold: bcd %b err %b want 1101 0", bcd_o4, err_o);
        end
    endtask

    task automatic test_gapped();
        strobe_cyc_q.delete();
        send_digit(4'b1000, 1'b0, 2);
        drain("gapped");
        checks++;
        if (strobe_cyc_q.size() != 1 || bcd_o4 !== 4'b0101) begin
            errors++;
            $display("FAIL gapped: strobes %0d bcd %b want 1 0101", strobe_cyc_q.size(), bcd_o4);
        end
    endtask

    task automatic test_resync();
        strobe_cyc_q.delete();
        push_ser(4'b0011, 0);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        push_ser(4'b0011, 1);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        send_digit(4'b0111, 1'b1, 0);
        drain("resync");
        checks++;
        if (strobe_cyc_q.size() != 1 || bcd_o4 !== 4'b0100) begin
            errors++;
            $display("FAIL resync: strobes %0d bcd %b want 1 0100", strobe_cyc_q.size(), bcd_o4);
        end
    endtask

    task automatic test_reset_mid();
        strobe_cyc_q.delete();
        push_ser(4'b0101, 0);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        push_ser(4'b0101, 1);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        do_reset();
        @(negedge clk_i);
        checks++;
        if (bcd_o4 !== 4'b0000 || strobe_cyc_q.size() != 0) begin
            errors++;
            $display("FAIL reset_mid: bcd %b strobes %0d want 0000 0", bcd_o4, strobe_cyc_q.size());
        end
        send_digit(4'd12, 1'b0, 0);
        drain("reset_mid");
        checks++;
        if (strobe_cyc_q.size() != 1 || bcd_o4 !== 4'b1001) begin
            errors++;
            $display("FAIL reset_mid_next: strobes %0d bcd %b want 1 1001",
                     strobe_cyc_q.size(), bcd_o4);
        end
    endtask

    task automatic test_reset_bit3();
        strobe_cyc_q.delete();
        for (int i = 0; i < 3; i++) begin
            push_ser(4'b0101, i);
            drive(1'b1, (i != 1), 1'b0, 1'b0);
        end
        push_ser(4'b0101, 3);
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        idle(3);
        checks++;
        if (bcd_o4 !== 4'b0000 || strobe_cyc_q.size() != 0) begin
            errors++;
            $display("FAIL reset_bit3: bcd %b strobes %0d want 0000 0", bcd_o4, strobe_cyc_q.size());
        end
        send_digit(4'd9, 1'b0, 0);
        drain("reset_bit3");
    endtask

    initial begin
        test_reset();
        test_legal_min();
        test_all_legal();
        test_illegal();
        test_gapped();
        test_resync();
        test_reset_mid();
        test_reset_bit3();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
